// File: rtl/sram1rw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram1rw_ctrl
//  Description : Request-side controller for the single-port SRAM1RW1024x64
//                macro. Turns a valid/ready request stream into the macro's
//                active-low CSB/WEB/OEB pins, absorbs the one-cycle registered
//                read latency and returns read data through a credit-guarded
//                response FIFO. Optionally zero-fills the array after reset.
//  Option      : SRAM1RW_CTRL_WRITE_ACK_EN - adds rsp_is_wr and makes every
//                accepted write return an in-order zero-data acknowledgement.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram1rw_ctrl #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 64,
    parameter int RSP_DEPTH      = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
`ifdef SRAM1RW_CTRL_WRITE_ACK_EN
    output logic              rsp_is_wr,
`endif
    output logic              init_done,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_i,
    input  logic [DATA_W-1:0] sram_o
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(RSP_DEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t ST_RESET = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  init_cnt;
    logic               inflight;
    logic [ADDR_W-1:0]  a_hold;
    logic [DATA_W-1:0]  i_hold;
    logic               fire;
    logic               pop;
    logic               push;
    logic [DATA_W-1:0]  push_data;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     occ;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [DATA_W-1:0]  fifo_data [RSP_DEPTH];
`ifdef SRAM1RW_CTRL_WRITE_ACK_EN
    logic               inflight_wr;
    logic               fifo_wr [RSP_DEPTH];
`endif

    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign push      = inflight;
    assign rsp_data  = fifo_data[rd_ptr];
    // init_done is forced low while reset is held, even when reset lands in RUN
    assign init_done = reset_n & (state == ST_RUN);
    // Occupancy including the read whose data lands at the end of this cycle
    assign occ = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};

`ifdef SRAM1RW_CTRL_WRITE_ACK_EN
    assign push_data = inflight_wr ? '0 : sram_o;
    assign rsp_is_wr = fifo_wr[rd_ptr];
`else
    assign push_data = sram_o;
`endif

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, credit check and combinational macro pin drive; reset_n gates
    // the strobes so the pins fall back to idle the instant reset asserts
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        fire      = 1'b0;
        sram_csb  = 1'b1;
        sram_web  = 1'b1;
        sram_oeb  = 1'b1;
        sram_a    = a_hold;
        sram_i    = i_hold;
        if (reset_n) begin
            case (state)
                ST_INIT: begin
                    sram_csb = 1'b0;
                    sram_web = 1'b0;
                    sram_a   = init_cnt;
                    sram_i   = '0;
                    if (init_cnt == '1) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    req_ready = (occ < CREDIT_MAX);
                    fire      = req_valid & req_ready;
                    sram_csb  = ~fire;
                    sram_web  = ~(fire & req_we);
                    sram_oeb  = ~(fire & ~req_we);
                    if (fire) begin
                        sram_a = req_addr;
                        sram_i = req_wdata;
                    end
                end
                default: state_nxt = ST_RESET;
            endcase
        end
    end

    // Init address counter, in-flight tracking and address/data hold registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt <= '0;
            inflight <= 1'b0;
            a_hold   <= '0;
            i_hold   <= '0;
`ifdef SRAM1RW_CTRL_WRITE_ACK_EN
            inflight_wr <= 1'b0;
`endif
        end else begin
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + ADDR_W'(1);
            end
`ifdef SRAM1RW_CTRL_WRITE_ACK_EN
            inflight    <= fire;
            inflight_wr <= fire & req_we;
`else
            inflight    <= fire & ~req_we;
`endif
            a_hold <= sram_a;
            i_hold <= sram_i;
        end
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Response FIFO storage; contents need no reset because count gates them
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_data;
`ifdef SRAM1RW_CTRL_WRITE_ACK_EN
            fifo_wr[wr_ptr]   <= inflight_wr;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram1rw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram1rw_ctrl
//  Description : Self-checking bench for sram1rw_ctrl. A behavioural macro
//                model sits on the SRAM pins; expected responses are queued at
//                request acceptance from a flat reference memory and popped by
//                an independent monitor whenever a response is consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram1rw_ctrl;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 64;
    localparam int RSP_DEPTH = 2;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clock     = 1'b0;
    logic              reset_n   = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_we    = 1'b0;
    logic [ADDR_W-1:0] req_addr  = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_ready = 1'b0;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              init_done;
    logic              sram_csb;
    logic              sram_web;
    logic              sram_oeb;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_i;
    logic [DATA_W-1:0] sram_o = '0;
    logic              got_is_wr;
`ifdef SRAM1RW_CTRL_WRITE_ACK_EN
    logic              rsp_is_wr;
    assign got_is_wr = rsp_is_wr;
`else
    assign got_is_wr = 1'b0;
`endif

    sram1rw_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RSP_DEPTH(RSP_DEPTH), .CLEAR_ON_RESET(1)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef SRAM1RW_CTRL_WRITE_ACK_EN
        .rsp_is_wr(rsp_is_wr),
`endif
        .init_done(init_done),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
        .sram_a(sram_a), .sram_i(sram_i), .sram_o(sram_o)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Behavioural SRAM macro: registered read, write on the same edge
    logic [DATA_W-1:0] macro_mem [DEPTH];
    always @(posedge clock) begin
        if (!sram_csb && !sram_web) macro_mem[sram_a] <= sram_i;
        if (!sram_csb && !sram_oeb) sram_o <= macro_mem[sram_a];
    end

    // Reference model: what the array should hold, and the responses owed
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W:0]   exp_q [$];

    // rsp_ready pattern: 0 = always ready, 1 = never ready, 2 = random
    int rr_mode = 1;
    always @(posedge clock) begin
        #1;
        case (rr_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compare every consumed response; check head stability under stall
    logic              hold_vld = 1'b0;
    logic [DATA_W-1:0] hold_dat;
    always @(negedge clock) begin
        if (reset_n && rsp_valid) begin
            if (rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", {got_is_wr, rsp_data}, 'x);
                end else begin
                    check("rsp_data", {got_is_wr, rsp_data}, exp_q.pop_front());
                end
                hold_vld = 1'b0;
            end else begin
                if (hold_vld) check("rsp_hold_stable", rsp_data, hold_dat);
                hold_dat = rsp_data;
                hold_vld = 1'b1;
            end
        end else begin
            hold_vld = 1'b0;
        end
    end

    // Record an accepted request in the reference model (called at the
    // sampling point of the cycle in which it fires)
    task automatic note_fire();
        if (req_we) begin
            ref_mem[req_addr] = req_wdata;
`ifdef SRAM1RW_CTRL_WRITE_ACK_EN
            exp_q.push_back({1'b1, {DATA_W{1'b0}}});
`endif
        end else begin
            exp_q.push_back({1'b0, ref_mem[req_addr]});
        end
    endtask

    // Issue one request and hold it until accepted; entered and left #1 after posedge
    task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        int  n    = 0;
        bit  done = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
        while (!done) begin
            @(negedge clock);
            if (req_ready) begin
                note_fire();
                done = 1;
            end else if (++n > 200) begin
                check("req_accept_timeout", 0, 1);
                done = 1;
            end
            @(posedge clock); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        rr_mode = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 500) begin
            @(posedge clock); #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic run_random(input int n);
        int issued = 0;
        int cyc    = 0;
        bit fired  = 1;
        while (issued < n && cyc < n * 30) begin
            if (fired || !req_valid) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_we    = 1'($urandom_range(0, 1));
                req_addr  = ADDR_W'($urandom_range(0, 31));
                req_wdata = {$urandom, $urandom};
            end
            @(negedge clock);
            fired = req_valid && req_ready;
            if (fired) begin
                note_fire();
                issued++;
            end
            @(posedge clock); #1;
            cyc++;
        end
        req_valid = 1'b0;
        check("random_issued", issued, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int acc;
        int run;
        int maxrun;
        int cyc;
        int stale;

        for (int i = 0; i < DEPTH; i++) begin
            macro_mem[i] = {$urandom, $urandom} | 64'h1;
            ref_mem[i]   = '0;
        end

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_init_done", init_done, 0);
        check("rst_pins_n", {sram_csb, sram_web, sram_oeb}, 3'b111);
        check("rst_sram_a", sram_a, 0);
        check("rst_sram_i", sram_i, 0);

        // Zero-fill: 1024 write cycles on consecutive addresses, then RUN
        reset_n = 1'b1;
        bad = 0;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clock);
            if (sram_csb !== 1'b0 || sram_web !== 1'b0 || req_ready !== 1'b0 ||
                init_done !== 1'b0 || sram_a !== ADDR_W'(k) || sram_i !== '0) bad++;
        end
        check("init_window_bad_cycles", bad, 0);
        @(negedge clock);
        check("init_done_cycle_1025", init_done, 1);
        check("req_ready_after_init", req_ready, 1);
        @(posedge clock); #1;

        // Cleared contents
        rr_mode = 0;
        do_req(0, 10'd0, '0);
        do_req(0, 10'd511, '0);
        do_req(0, 10'd1023, '0);
        wait_idle();

        // Write then read the same address in consecutive cycles; 2-cycle latency
        do_req(1, 10'h3FF, 64'hDEADBEEF_CAFEF00D);
        do_req(0, 10'h3FF, '0);
`ifndef SRAM1RW_CTRL_WRITE_ACK_EN
        @(negedge clock);
        check("rd_latency_n1_valid", rsp_valid, 0);
`endif
        @(posedge clock); #1;
        @(negedge clock);
        check("rd_latency_n2_valid", rsp_valid, 1);
        @(posedge clock); #1;
        wait_idle();

        // Back-to-back reads with rsp_ready held high
        for (int i = 0; i < 16; i++) do_req(1, ADDR_W'(256 + i), {$urandom, $urandom});
        wait_idle();
        bad = 0; run = 0; maxrun = 0;
        for (int i = 0; i < 20; i++) begin
            req_valid = (i < 16);
            req_we    = 1'b0;
            req_addr  = ADDR_W'(256 + i);
            @(negedge clock);
            if (req_valid) begin
                if (req_ready) note_fire();
                else bad++;
            end
            if (rsp_valid) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            @(posedge clock); #1;
        end
        req_valid = 1'b0;
        check("b2b_ready_drops", bad, 0);
        check("b2b_valid_run", maxrun, 16);
        wait_idle();

        // Backpressure: only RSP_DEPTH reads accepted while the consumer stalls
        rr_mode = 1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = ADDR_W'(256 + acc);
            @(negedge clock);
            if (req_ready) begin note_fire(); acc++; end
            @(posedge clock); #1;
        end
        check("stall_accepted", acc, 2);
        @(negedge clock);
        check("stall_req_ready", req_ready, 0);
        check("stall_rsp_valid", rsp_valid, 1);
        check("stall_head_data", rsp_data, ref_mem[256]);
        @(posedge clock); #1;
        rr_mode = 0;
        cyc = 0;
        while (acc < 4 && cyc < 50) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = ADDR_W'(256 + acc);
            @(negedge clock);
            if (req_ready) begin note_fire(); acc++; end
            @(posedge clock); #1;
            cyc++;
        end
        req_valid = 1'b0;
        check("stall_resume_accepted", acc, 4);
        wait_idle();

        // Reset with one response queued and one read in flight
        rr_mode = 1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        do_req(0, 10'h101, '0);
        do_req(0, 10'h102, '0);
        check("pre_reset_rsp_valid", rsp_valid, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_sram_csb", sram_csb, 1);
        check("midrst_req_ready", req_ready, 0);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        rr_mode = 0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        cyc = 0; stale = 0;
        while (cyc < 1100) begin
            @(negedge clock);
            cyc++;
            if (rsp_valid) stale++;
            if (init_done) break;
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        check("reinit_no_stale_rsp", stale, 0);
        check("reinit_cycles", cyc, 1025);

        // Randomized traffic with random backpressure
        rr_mode = 2;
        run_random(400);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
